// File: rtl/dmem_resp_port.sv
// Data-memory responder: valid/ready request in, fixed-latency access to an internal byte array, held response out.
// Optional DMEM_RESP_MISALIGN_EN: serve misaligned in-bounds accesses byte-wise instead of flagging them.
module dmem_resp_port #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned       CNT_W     = 16;
  localparam logic [ADDR_W:0]   MEM_BYTES = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_len;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;
  logic              r_err;
  logic [7:0]        r_mem [2**ADDR_W];

  logic [7:0]        w_be;
  logic [3:0]        w_size;
  logic              w_len_err, w_bound_err, w_align_err, w_err, w_done;
  logic [ADDR_W:0]   w_end;
  logic [63:0]       w_rd;

  assign w_done = (r_state == S_WAIT) && (r_cnt == '0);

  always_comb begin
    w_be      = '0;
    w_size    = '0;
    w_len_err = 1'b0;
    case (r_len)
      4'b0001: begin w_be = 8'h01; w_size = 4'd1; end
      4'b0010: begin w_be = 8'h03; w_size = 4'd2; end
      4'b0100: begin w_be = 8'h0F; w_size = 4'd4; end
      4'b1000: begin w_be = 8'hFF; w_size = 4'd8; end
      default: w_len_err = 1'b1;
    endcase
  end

  // End address is one bit wider than the array so the top boundary is detected without wrap.
  assign w_end       = {1'b0, r_addr} + (ADDR_W+1)'(w_size);
  assign w_bound_err = w_end > MEM_BYTES;
`ifdef DMEM_RESP_MISALIGN_EN
  assign w_align_err = 1'b0;
`else
  assign w_align_err = (r_addr[2:0] & (w_size[2:0] - 3'd1)) != 3'd0;
`endif
  assign w_err = w_len_err | w_bound_err | w_align_err;

  always_comb begin
    w_rd = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (w_be[i]) w_rd[8*i +: 8] = r_mem[r_addr + ADDR_W'(i)];
  end

  // Array is deliberately excluded from reset; rst only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && w_done && r_we && !w_err)
      for (int unsigned i = 0; i < 8; i++)
        if (w_be[i]) r_mem[r_addr + ADDR_W'(i)] <= r_wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_addr  <= req_addr;
          r_len   <= req_len;
          r_wdata <= req_wdata;
          r_cnt   <= req_we ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
        end
        S_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_rdata <= (w_err || r_we) ? '0 : w_rd;
            r_err   <= w_err;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)  w_next = S_WAIT;
      S_WAIT:  if (w_done)     w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    resp_rdata = r_rdata;
    resp_err   = r_err;
  end

endmodule

// File: tb/tb_dmem_resp_port.sv
// Scoreboarded bench for dmem_resp_port: byte-array model predicts data, error and latency per request.
module tb_dmem_resp_port;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;
  logic [63:0]       req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [63:0]       resp_rdata;

  logic [7:0]  mdl [2**ADDR_W];
  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  dmem_resp_port #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  function automatic int len_size(input logic [3:0] len);
    case (len)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  // Predicts the response from the model array and pushes it; store effects applied to the model here.
  task automatic push_expect(input logic we, input int addr, input logic [3:0] len, input logic [63:0] wd);
    exp_t e;
    int   sz;
    logic err;
    sz  = len_size(len);
    err = (sz == 0) || (addr + sz > 2**ADDR_W);
`ifndef DMEM_RESP_MISALIGN_EN
    if (sz != 0 && (addr % sz) != 0) err = 1'b1;
`endif
    e.rdata = '0;
    e.err   = err;
    e.lat   = we ? WR_LAT : RD_LAT;
    if (!err) begin
      for (int i = 0; i < sz; i++) begin
        if (we) mdl[addr+i] = wd[8*i +: 8];
        else    e.rdata[8*i +: 8] = mdl[addr+i];
      end
    end
    q.push_back(e);
  endtask

  task automatic do_req(input logic we, input int addr, input logic [3:0] len, input logic [63:0] wd,
                        input string name);
    exp_t e;
    int   n;
    push_expect(we, addr, len, wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = ADDR_W'(addr); req_len = len; req_wdata = wd;
    resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL %s accept timeout: req_ready=%b required 1", name, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    e = q.pop_front();
    last_rdata = resp_rdata;
    last_err   = resp_err;
    total++;
    if (n !== e.lat) begin
      bad++; $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
    end
    total++;
    if (resp_err !== e.err) begin
      bad++; $display("FAIL %s err: got %b required %b", name, resp_err, e.err);
    end
    total++;
    if (resp_rdata !== e.rdata) begin
      bad++; $display("FAIL %s rdata: got %h required %h", name, resp_rdata, e.rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = 4'b0001;
    req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err} !== 3'b100) begin
      bad++; $display("FAIL reset flags: got rdy/vld/err=%b%b%b required 100", req_ready, resp_valid, resp_err);
    end
    total++;
    if (resp_rdata !== 64'h0) begin
      bad++; $display("FAIL reset rdata: got %h required 0", resp_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    do_req(1'b1, 'h010, 4'b1000, 64'h1122334455667788, "st8");
    do_req(1'b0, 'h010, 4'b1000, '0, "ld8");
    total++;
    if (last_rdata !== 64'h1122334455667788) begin
      bad++; $display("FAIL ld8 const: got %h required 1122334455667788", last_rdata);
    end
  endtask

  task automatic test_subword();
    do_req(1'b0, 'h011, 4'b0001, '0, "ld1");
    total++;
    if (last_rdata !== 64'h77) begin
      bad++; $display("FAIL ld1 const: got %h required 77", last_rdata);
    end
    do_req(1'b0, 'h012, 4'b0010, '0, "ld2");
    total++;
    if (last_rdata !== 64'h5566) begin
      bad++; $display("FAIL ld2 const: got %h required 5566", last_rdata);
    end
    do_req(1'b1, 'h014, 4'b0100, 64'hFFFF_FFFF_A1B2_C3D4, "st4");
    do_req(1'b0, 'h010, 4'b1000, '0, "ld8_after_st4");
  endtask

  task automatic test_errors();
    do_req(1'b0, 'h7FE, 4'b0100, '0, "ld4_oob");
    total++;
    if (last_err !== 1'b1) begin
      bad++; $display("FAIL ld4_oob flag: got %b required 1", last_err);
    end
    do_req(1'b0, 'h000, 4'b0011, '0, "len_bad");
    total++;
    if (last_err !== 1'b1) begin
      bad++; $display("FAIL len_bad flag: got %b required 1", last_err);
    end
    do_req(1'b1, 'h7F8, 4'b1000, 64'hDEAD_BEEF_0BAD_F00D, "st8_top");
    do_req(1'b0, 'h7FE, 4'b0010, '0, "ld2_top");
    do_req(1'b1, 'h7FC, 4'b1000, 64'h1, "st8_oob");
    do_req(1'b0, 'h7F8, 4'b1000, '0, "ld8_top");
  endtask

  task automatic test_misalign();
    do_req(1'b1, 'h000, 4'b1000, 64'h0807_0605_0403_0201, "st8_base");
    do_req(1'b1, 'h002, 4'b0100, 64'hCAFE_F00D, "st4_mis");
    do_req(1'b0, 'h000, 4'b1000, '0, "ld8_base");
    do_req(1'b0, 'h002, 4'b0100, '0, "ld4_mis");
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 64; a += 8)
      do_req(1'b1, 'h40 + a, 4'b1000, {$urandom, $urandom}, "init");
    for (int k = 0; k < 24; k++) begin
      logic [3:0] len;
      int         sz, addr;
      len = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) len = 4'b0110;
      sz   = len_size(len);
      addr = 'h40 + $urandom_range(0, 64 - (sz == 0 ? 8 : sz));
      do_req($urandom_range(0, 1) == 1, addr, len, {$urandom, $urandom}, "rand");
    end
  endtask

  task automatic test_stall_and_reset();
    logic [63:0] held;
    int          n;
    do_req(1'b1, 'h100, 4'b1000, 64'hA5A5_5A5A_1234_5678, "st_pre");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 'h100; req_len = 4'b1000; resp_ready = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    held = resp_rdata;
    total++;
    if (held !== 64'hA5A5_5A5A_1234_5678) begin
      bad++; $display("FAIL stall data: got %h required a5a55a5a12345678", held);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== held) begin
        bad++;
        $display("FAIL stall hold c%0d: vld=%b rdy=%b rdata=%h required 1 0 %h", c, resp_valid, req_ready, resp_rdata, held);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL stall release: vld=%b rdy=%b required 0 1", resp_valid, req_ready);
    end
    do_req(1'b0, 'h100, 4'b1000, '0, "ld_after_ignored");

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 'h100; req_len = 4'b1000; req_wdata = 64'h0;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'h0) begin
      bad++; $display("FAIL rst_mid: rdy=%b vld=%b rdata=%h required 1 0 0", req_ready, resp_valid, resp_rdata);
    end
    do_req(1'b0, 'h100, 4'b1000, '0, "ld_after_rst");
    total++;
    if (last_rdata !== 64'hA5A5_5A5A_1234_5678) begin
      bad++; $display("FAIL rst_mid data: got %h required a5a55a5a12345678", last_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_subword();
    test_errors();
    test_misalign();
    test_back_to_back();
    test_stall_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
